// File: rtl/heartbeat_watchdog_pkg.sv
// Shared definitions for the heartbeat watchdog: state encodings and the
// default timing parameters used by the top level.
package heartbeat_watchdog_pkg;

    localparam int WDG_CNT_W_DEF      = 24;
    localparam int WDG_TIMEOUT_DEF    = 1_000_000;
    localparam int WDG_WINDOW_MIN_DEF = 0;

    // 2'b11 is deliberately unused; the FSM treats it as a fault.
    typedef enum logic [1:0] {
        S_DIS = 2'b00,
        S_RUN = 2'b01,
        S_EXP = 2'b10
    } wdg_state_t;

endpackage

// File: rtl/heartbeat_watchdog_if.sv
// Control and status bundle between the machine controller side and the
// heartbeat watchdog.
interface heartbeat_watchdog_if;

    logic enable;
    logic heartbeat;
    logic ack_pulse;
    logic wdg_to;
    logic early_kick;
    logic armed;

    modport master (
        output enable, heartbeat, ack_pulse,
        input  wdg_to, early_kick, armed
    );

    modport slave (
        input  enable, heartbeat, ack_pulse,
        output wdg_to, early_kick, armed
    );

endinterface

// File: rtl/heartbeat_watchdog_sync_edge_det.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on every
// edge (rising or falling) of an asynchronous input. Reusable for the e-stop
// and acknowledge buttons.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Resynchronize the input and keep one cycle of history for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_edge = r_s2 ^ r_s3;

endmodule

// File: rtl/heartbeat_watchdog.sv
// Windowed heartbeat watchdog. Missing kicks (timeout) and kicks arriving
// before WINDOW_MIN cycles (window violation) both latch wdg_to until the
// operator acknowledge.
module heartbeat_watchdog
    import heartbeat_watchdog_pkg::*;
#(
    parameter int CNT_W      = WDG_CNT_W_DEF,
    parameter int TIMEOUT    = WDG_TIMEOUT_DEF,
    parameter int WINDOW_MIN = WDG_WINDOW_MIN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    heartbeat_watchdog_if.slave  bus
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

    wdg_state_t       r_state;
    wdg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_first;
    logic             w_first_nxt;
    logic             r_wdg_to;
    logic             w_wdg_to_nxt;
    logic             r_early;
    logic             w_early_nxt;
    logic             r_armed;
    logic             w_kick;
    logic             w_window_viol;

    sync_edge_det u_hb_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (bus.heartbeat),
        .o_edge  (w_kick)
    );

    // The first kick after reset/enable/ack is exempt: it may be the
    // spurious edge left by the synchronizer's reset values.
    generate
        if (WINDOW_MIN > 0) begin : g_window
            localparam logic [CNT_W-1:0] LP_WMIN = CNT_W'(WINDOW_MIN);
            assign w_window_viol = !r_first && (r_count < LP_WMIN);
        end else begin : g_no_window
            assign w_window_viol = 1'b0;
        end
    endgenerate

    // Next-state, counter and fault flags; RUN checks are in priority order
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_first_nxt  = r_first;
        w_wdg_to_nxt = r_wdg_to;
        w_early_nxt  = r_early;
        case (r_state)
            S_DIS: begin
                w_count_nxt  = '0;
                w_wdg_to_nxt = 1'b0;
                w_early_nxt  = 1'b0;
                if (bus.enable) begin
                    w_state_nxt = S_RUN;
                    w_first_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    w_state_nxt = S_DIS;
                    w_count_nxt = '0;
                end else if (w_kick && w_window_viol) begin
                    w_state_nxt  = S_EXP;
                    w_wdg_to_nxt = 1'b1;
                    w_early_nxt  = 1'b1;
                end else if (w_kick) begin
                    w_count_nxt = '0;
                    w_first_nxt = 1'b0;
                end else if (r_count == LP_LAST) begin
                    w_state_nxt  = S_EXP;
                    w_wdg_to_nxt = 1'b1;
                    w_early_nxt  = 1'b0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            S_EXP: begin
                // Kicks are ignored here; only the acknowledge leaves.
                if (bus.ack_pulse) begin
                    w_state_nxt  = S_RUN;
                    w_count_nxt  = '0;
                    w_first_nxt  = 1'b1;
                    w_wdg_to_nxt = 1'b0;
                    w_early_nxt  = 1'b0;
                end
            end
            default: begin
                // Corrupted state: fail safe into the latched fault.
                w_state_nxt  = S_EXP;
                w_wdg_to_nxt = 1'b1;
            end
        endcase
    end

    // State, counter and registered outputs; live (RUN) straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_count  <= '0;
            r_first  <= 1'b1;
            r_wdg_to <= 1'b0;
            r_early  <= 1'b0;
            r_armed  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_first  <= w_first_nxt;
            r_wdg_to <= w_wdg_to_nxt;
            r_early  <= w_early_nxt;
            r_armed  <= (w_state_nxt == S_RUN);
        end
    end

    assign bus.wdg_to     = r_wdg_to;
    assign bus.early_kick = r_early;
    assign bus.armed      = r_armed;

endmodule

// File: tb/tb_heartbeat_watchdog.sv
// Bench for heartbeat_watchdog with TIMEOUT=16, WINDOW_MIN=4: directed
// scenarios plus randomized stimulus against a timestamp-based reference.
module tb_heartbeat_watchdog;

    localparam int TO = 16;
    localparam int WM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    heartbeat_watchdog_if bus_if ();

    heartbeat_watchdog #(
        .CNT_W      (8),
        .TIMEOUT    (TO),
        .WINDOW_MIN (WM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Reference: remember the edge number of the last counter clear; the
    // counter value at edge n is n - m_last - 1. A heartbeat change sampled
    // at one edge reaches the counter two edges later.
    int         m_cyc   = 0;
    int         m_last  = 0;
    logic [2:0] m_hb    = 3'b000;
    bit         m_on    = 1'b1;
    bit         m_fault = 1'b0;
    bit         m_early = 1'b0;
    bit         m_first = 1'b1;
    logic       m_kick;
    int         m_age;

    assign m_kick = m_hb[1] ^ m_hb[2];
    assign m_age  = m_cyc + 1 - m_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hb    <= 3'b000;
            m_last  <= m_cyc;
            m_on    <= 1'b1;
            m_fault <= 1'b0;
            m_early <= 1'b0;
            m_first <= 1'b1;
        end else begin
            m_cyc <= m_cyc + 1;
            m_hb  <= {m_hb[1:0], bus_if.heartbeat};
            if (m_fault) begin
                if (bus_if.ack_pulse) begin
                    m_fault <= 1'b0;
                    m_early <= 1'b0;
                    m_on    <= 1'b1;
                    m_first <= 1'b1;
                    m_last  <= m_cyc + 1;
                end
            end else if (!m_on) begin
                if (bus_if.enable) begin
                    m_on    <= 1'b1;
                    m_first <= 1'b1;
                    m_last  <= m_cyc + 1;
                end
            end else if (!bus_if.enable) begin
                m_on <= 1'b0;
            end else if (m_kick && !m_first && m_age <= WM) begin
                m_fault <= 1'b1;
                m_early <= 1'b1;
            end else if (m_kick) begin
                m_last  <= m_cyc + 1;
                m_first <= 1'b0;
            end else if (m_age == TO) begin
                m_fault <= 1'b1;
            end
        end
    end

    // Compare every cycle against the reference, away from the active edge
    always @(negedge clk) begin
        checks++;
        if (bus_if.wdg_to !== m_fault) begin
            failures++;
            $display("FAIL model_wdg_to got=%0b exp=%0b cyc=%0d", bus_if.wdg_to, m_fault, m_cyc);
        end
        checks++;
        if (bus_if.early_kick !== m_early) begin
            failures++;
            $display("FAIL model_early_kick got=%0b exp=%0b cyc=%0d", bus_if.early_kick, m_early, m_cyc);
        end
        checks++;
        if (bus_if.armed !== (m_on && !m_fault)) begin
            failures++;
            $display("FAIL model_armed got=%0b exp=%0b cyc=%0d", bus_if.armed, (m_on && !m_fault), m_cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic toggle_hb();
        bus_if.heartbeat = ~bus_if.heartbeat;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        bus_if.enable     = 1'b1;
        bus_if.heartbeat  = 1'b0;
        bus_if.ack_pulse  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL reset_wdg_to got=%0b exp=0", bus_if.wdg_to);
        end
        checks++;
        if (bus_if.early_kick !== 1'b0) begin
            failures++; $display("FAIL reset_early_kick got=%0b exp=0", bus_if.early_kick);
        end
        checks++;
        if (bus_if.armed !== 1'b1) begin
            failures++; $display("FAIL reset_armed got=%0b exp=1", bus_if.armed);
        end
    endtask

    task automatic test_no_timeout();
        apply_reset();
        for (int e = 1; e <= TO; e++) begin
            tick(1);
            if (e == TO - 1) begin
                checks++;
                if (bus_if.wdg_to !== 1'b0) begin
                    failures++; $display("FAIL timeout_before_edge16 got=%0b exp=0", bus_if.wdg_to);
                end
            end
        end
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL timeout_edge16 got=%0b exp=1", bus_if.wdg_to);
        end
        checks++;
        if (bus_if.early_kick !== 1'b0) begin
            failures++; $display("FAIL timeout_early_kick got=%0b exp=0", bus_if.early_kick);
        end
        checks++;
        if (bus_if.armed !== 1'b0) begin
            failures++; $display("FAIL timeout_armed got=%0b exp=0", bus_if.armed);
        end
        for (int i = 0; i < 100; i++) begin
            tick(1);
            checks++;
            if (bus_if.wdg_to !== 1'b1) begin
                failures++; $display("FAIL timeout_sticky got=%0b exp=1 i=%0d", bus_if.wdg_to, i);
            end
        end
    endtask

    task automatic test_acknowledge();
        bus_if.enable = 1'b0;
        tick(5);
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL ack_disable_keeps_fault got=%0b exp=1", bus_if.wdg_to);
        end
        bus_if.enable = 1'b1;
        tick(2);
        bus_if.ack_pulse = 1'b1;
        tick(1);
        bus_if.ack_pulse = 1'b0;
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL ack_clears_wdg_to got=%0b exp=0", bus_if.wdg_to);
        end
        checks++;
        if (bus_if.armed !== 1'b1) begin
            failures++; $display("FAIL ack_rearms got=%0b exp=1", bus_if.armed);
        end
        tick(TO - 1);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL ack_timeout_too_soon got=%0b exp=0", bus_if.wdg_to);
        end
        tick(1);
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL ack_next_timeout got=%0b exp=1", bus_if.wdg_to);
        end
    endtask

    // Starts in the latched fault left by test_acknowledge.
    task automatic test_ack_with_kick();
        toggle_hb();
        tick(2);
        bus_if.ack_pulse = 1'b1;
        tick(1);
        bus_if.ack_pulse = 1'b0;
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL ack_kick_clear got=%0b exp=0", bus_if.wdg_to);
        end
        // This kick lands at count 2 and must be absorbed as the first one.
        toggle_hb();
        tick(3);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL ack_kick_first_absorbed got=%0b exp=0", bus_if.wdg_to);
        end
        tick(TO - 1);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL ack_kick_timeout_too_soon got=%0b exp=0", bus_if.wdg_to);
        end
        tick(1);
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL ack_kick_timeout got=%0b exp=1", bus_if.wdg_to);
        end
    endtask

    task automatic test_steady_kicks();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0) toggle_hb();
            tick(1);
            checks++;
            if (bus_if.wdg_to !== 1'b0 || bus_if.armed !== 1'b1) begin
                failures++;
                $display("FAIL steady_kicks wdg_to=%0b armed=%0b exp wdg_to=0 armed=1 i=%0d",
                         bus_if.wdg_to, bus_if.armed, i);
            end
        end
    endtask

    task automatic test_early_kick();
        apply_reset();
        toggle_hb();
        tick(8);
        toggle_hb();
        tick(2);
        toggle_hb();
        tick(2);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL early_before got=%0b exp=0", bus_if.wdg_to);
        end
        tick(1);
        checks++;
        if (bus_if.wdg_to !== 1'b1 || bus_if.early_kick !== 1'b1) begin
            failures++;
            $display("FAIL early_fault wdg_to=%0b early_kick=%0b exp 1 1", bus_if.wdg_to, bus_if.early_kick);
        end
    endtask

    // Toggles g cycles apart reach the counter when it holds g-1.
    task automatic test_kick_boundary();
        apply_reset();
        toggle_hb();
        tick(16);
        toggle_hb();
        tick(3);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL boundary_count15 got=%0b exp=0", bus_if.wdg_to);
        end
        tick(2);
        toggle_hb();
        tick(3);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL boundary_count4 got=%0b exp=0", bus_if.wdg_to);
        end
        tick(1);
        toggle_hb();
        tick(3);
        checks++;
        if (bus_if.wdg_to !== 1'b1 || bus_if.early_kick !== 1'b1) begin
            failures++;
            $display("FAIL boundary_count3 wdg_to=%0b early_kick=%0b exp 1 1", bus_if.wdg_to, bus_if.early_kick);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        toggle_hb();
        tick(3 + 9);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.wdg_to !== 1'b0 || bus_if.early_kick !== 1'b0 || bus_if.armed !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_count wdg_to=%0b early=%0b armed=%0b exp 0 0 1",
                     bus_if.wdg_to, bus_if.early_kick, bus_if.armed);
        end
        tick(1);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL reset_mid_reach_exp got=%0b exp=1", bus_if.wdg_to);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.wdg_to !== 1'b0 || bus_if.early_kick !== 1'b0 || bus_if.armed !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_exp wdg_to=%0b early=%0b armed=%0b exp 0 0 1",
                     bus_if.wdg_to, bus_if.early_kick, bus_if.armed);
        end
        // Synchronizer flops restart at 0 with heartbeat high: the first kick
        // arrives at count 2 and must be taken as a legal clear.
        bus_if.heartbeat = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL reset_first_kick got=%0b exp=0", bus_if.wdg_to);
        end
        tick(TO - 1);
        checks++;
        if (bus_if.wdg_to !== 1'b0) begin
            failures++; $display("FAIL reset_first_kick_cleared got=%0b exp=0", bus_if.wdg_to);
        end
        tick(1);
        checks++;
        if (bus_if.wdg_to !== 1'b1) begin
            failures++; $display("FAIL reset_first_kick_timeout got=%0b exp=1", bus_if.wdg_to);
        end
    endtask

    task automatic test_random();
        int mode;
        int p;
        mode = 0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 80 == 0) mode = int'($urandom_range(0, 3));
            case (mode)
                0:       p = 0;
                1:       p = 3;
                2:       p = 9;
                default: p = 14;
            endcase
            if (p != 0 && $urandom_range(0, p - 1) == 0) toggle_hb();
            bus_if.ack_pulse = ($urandom_range(0, 19) == 0);
            if (bus_if.enable) begin
                if ($urandom_range(0, 149) == 0) bus_if.enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                bus_if.enable = 1'b1;
            end
            tick(1);
        end
        bus_if.ack_pulse = 1'b0;
        bus_if.enable    = 1'b1;
        tick(2);
    endtask

    initial begin
        bus_if.enable    = 1'b1;
        bus_if.heartbeat = 1'b0;
        bus_if.ack_pulse = 1'b0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_no_timeout();
        test_acknowledge();
        test_ack_with_kick();
        test_steady_kicks();
        test_early_kick();
        test_kick_boundary();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
